// File: rtl/holo_bus_pkg.sv
// Shared bus widths and memory-controller state encoding used by the core
// and by the data memory.
package holo_bus_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 8;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_SERVE = 1'b1
   } mem_state_t;

endpackage

// File: rtl/holo_byte_ram.sv
// DEPTH x 8 byte array: one synchronous write port, one synchronous read port.
// No reset on the storage or read register; contents come from the clear
// sequence in the controller.
module holo_byte_ram
   import holo_bus_pkg::*;
#(
   parameter int ADDR_BITS = 10
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [ADDR_BITS-1:0] waddr,
   input  logic [DATA_W-1:0]    wdata,
   input  logic                 re,
   input  logic [ADDR_BITS-1:0] raddr,
   output logic [DATA_W-1:0]    rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_BITS];

   // Write port: store one byte per enabled cycle.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read port: register the addressed byte; holds between reads.
   always_ff @(posedge clk) begin
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/holo_data_mem.sv
// Byte-addressed data memory for the core. After reset it clears every byte
// to INIT_VAL (one byte per cycle), then serves single-cycle-latency reads and
// writes. Accesses outside [BASE_ADDR, BASE_ADDR+DEPTH) raise a one-cycle ERR.
module holo_data_mem
   import holo_bus_pkg::*;
#(
   parameter int                ADDR_BITS = 10,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
   parameter logic [DATA_W-1:0] INIT_VAL  = 8'h00
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              DATA_CE,
   input  logic              DATA_OE,
   input  logic              DATA_WE,
   input  logic [ADDR_W-1:0] DATA_ADDR,
   input  logic [DATA_W-1:0] DATA_OUT,
   output logic [DATA_W-1:0] DATA_IN,
   output logic              RVALID,
   output logic              READY,
   output logic              ERR
);

   localparam int                   DEPTH    = 2**ADDR_BITS;
   localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(DEPTH - 1);

   mem_state_t           state_q, state_d;
   logic [ADDR_BITS-1:0] clr_cnt_q, clr_cnt_d;

   logic [ADDR_W-1:0]    off_p0;
   logic                 in_range_p0;
   logic                 acc_p0, wr_p0, rd_p0;

   logic                 ram_we, ram_re;
   logic [ADDR_BITS-1:0] ram_waddr;
   logic [DATA_W-1:0]    ram_wdata, ram_rdata;

   logic                 vld_p1, err_p1, rd_hit_p1;

   // ---- stage p0: decode of the bus request ----
   assign READY       = (state_q == ST_SERVE);
   assign off_p0      = DATA_ADDR - BASE_ADDR;
   assign in_range_p0 = (off_p0 < ADDR_W'(DEPTH));
   assign acc_p0      = READY & DATA_CE & (DATA_WE | DATA_OE);
   assign wr_p0       = acc_p0 & DATA_WE;
   assign rd_p0       = acc_p0 & ~DATA_WE;
   assign ram_re      = rd_p0 & in_range_p0;

   // State and clear-index registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_CLEAR;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   // Next state and RAM write-port mux: clear sweep owns the port in CLEAR.
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      ram_we    = 1'b0;
      ram_waddr = off_p0[ADDR_BITS-1:0];
      ram_wdata = DATA_OUT;
      case (state_q)
         ST_CLEAR: begin
            ram_we    = 1'b1;
            ram_waddr = clr_cnt_q;
            ram_wdata = INIT_VAL;
            clr_cnt_d = clr_cnt_q + ADDR_BITS'(1);
            if (clr_cnt_q == LAST_IDX) begin
               state_d = ST_SERVE;
            end
         end
         ST_SERVE: begin
            ram_we = wr_p0 & in_range_p0;
         end
         default: begin
            state_d = ST_CLEAR;
         end
      endcase
   end

   holo_byte_ram #(
      .ADDR_BITS (ADDR_BITS)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .re    (ram_re),
      .raddr (off_p0[ADDR_BITS-1:0]),
      .rdata (ram_rdata)
   );

   // ---- stage p1: read/error response flags ----
   // rd_hit_p1 selects RAM data vs. zero; it only changes on a read, so
   // DATA_IN holds between reads and drops to zero at once on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1    <= 1'b0;
         err_p1    <= 1'b0;
         rd_hit_p1 <= 1'b0;
      end else begin
         vld_p1 <= rd_p0;
         err_p1 <= acc_p0 & ~in_range_p0;
         if (rd_p0) begin
            rd_hit_p1 <= in_range_p0;
         end
      end
   end

   assign DATA_IN = rd_hit_p1 ? ram_rdata : '0;
   assign RVALID  = vld_p1;
   assign ERR     = err_p1;

endmodule

// File: tb/tb_holo_data_mem.sv
// Directed bench for holo_data_mem: instance A at BASE_ADDR 0, instance B at
// BASE_ADDR 0x100, both with ADDR_BITS=4 (16 bytes).
module tb_holo_data_mem;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        a_ce = 0, a_oe = 0, a_we = 0;
   logic [31:0] a_addr = '0;
   logic [7:0]  a_wd = '0;
   logic [7:0]  a_din;
   logic        a_rvalid, a_ready, a_err;

   logic        b_ce = 0, b_oe = 0, b_we = 0;
   logic [31:0] b_addr = '0;
   logic [7:0]  b_wd = '0;
   logic [7:0]  b_din;
   logic        b_rvalid, b_ready, b_err;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   holo_data_mem #(.ADDR_BITS(4), .BASE_ADDR(32'h0000_0000), .INIT_VAL(8'h00)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .DATA_CE(a_ce), .DATA_OE(a_oe), .DATA_WE(a_we),
      .DATA_ADDR(a_addr), .DATA_OUT(a_wd), .DATA_IN(a_din), .RVALID(a_rvalid),
      .READY(a_ready), .ERR(a_err)
   );

   holo_data_mem #(.ADDR_BITS(4), .BASE_ADDR(32'h0000_0100), .INIT_VAL(8'h00)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .DATA_CE(b_ce), .DATA_OE(b_oe), .DATA_WE(b_we),
      .DATA_ADDR(b_addr), .DATA_OUT(b_wd), .DATA_IN(b_din), .RVALID(b_rvalid),
      .READY(b_ready), .ERR(b_err)
   );

   // One bus cycle on instance A; returns #1 after the accepting edge.
   task automatic a_cyc(input logic ce, input logic we, input logic oe,
                        input logic [31:0] addr, input logic [7:0] wd);
      a_ce = ce; a_we = we; a_oe = oe; a_addr = addr; a_wd = wd;
      @(posedge clk); #1;
      a_ce = 0; a_we = 0; a_oe = 0;
   endtask

   task automatic b_cyc(input logic ce, input logic we, input logic oe,
                        input logic [31:0] addr, input logic [7:0] wd);
      b_ce = ce; b_we = we; b_oe = oe; b_addr = addr; b_wd = wd;
      @(posedge clk); #1;
      b_ce = 0; b_we = 0; b_oe = 0;
   endtask

   task automatic test_reset;
      int cnt;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({a_ready, a_rvalid, a_err, a_din} !== 11'd0) begin
         n_fail++;
         $display("FAIL reset_outputs_a: got rdy/rv/err/din=%b%b%b/%h, want 000/00", a_ready, a_rvalid, a_err, a_din);
      end
      n_cmp++;
      if (b_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ready_b: got %b, want 0", b_ready);
      end
      rst_n = 1'b1;
      cnt = 0;
      while (a_ready !== 1'b1 && cnt < 40) begin
         @(posedge clk); #1;
         cnt++;
      end
      n_cmp++;
      if (cnt !== 16) begin
         n_fail++;
         $display("FAIL clear_cycles: READY low for %0d cycles, want 16", cnt);
      end
      for (int i = 0; i < 16; i++) begin
         a_cyc(1, 0, 1, 32'(i), 8'h00);
         n_cmp++;
         if ({a_rvalid, a_din} !== 9'h100) begin
            n_fail++;
            $display("FAIL clear_byte_%0d: got rv/din=%b/%h, want 1/00", i, a_rvalid, a_din);
         end
      end
   endtask

   task automatic test_write_read;
      a_cyc(1, 1, 0, 32'h3, 8'hA5);
      n_cmp++;
      if ({a_rvalid, a_err, a_din} !== 10'h000) begin
         n_fail++;
         $display("FAIL wr_no_resp: got rv/err/din=%b/%b/%h, want 0/0/00", a_rvalid, a_err, a_din);
      end
      a_cyc(1, 0, 1, 32'h3, 8'h00);
      n_cmp++;
      if ({a_rvalid, a_din} !== 9'h1A5) begin
         n_fail++;
         $display("FAIL wr_then_rd: got rv/din=%b/%h, want 1/a5", a_rvalid, a_din);
      end
      a_cyc(0, 0, 0, 32'h0, 8'h00);
      n_cmp++;
      if ({a_rvalid, a_din} !== 9'h0A5) begin
         n_fail++;
         $display("FAIL rd_hold: got rv/din=%b/%h, want 0/a5", a_rvalid, a_din);
      end
   endtask

   task automatic test_le_word;
      logic [31:0] word;
      logic [7:0]  exp_b;
      word = 32'hDEAD_BEEF;
      for (int i = 0; i < 4; i++) a_cyc(1, 1, 0, 32'h8 + 32'(i), word[8*i +: 8]);
      for (int i = 0; i < 4; i++) begin
         exp_b = word[8*i +: 8];
         a_cyc(1, 0, 1, 32'h8 + 32'(i), 8'h00);
         n_cmp++;
         if ({a_rvalid, a_din} !== {1'b1, exp_b}) begin
            n_fail++;
            $display("FAIL le_word_byte_%0d: got rv/din=%b/%h, want 1/%h", i, a_rvalid, a_din, exp_b);
         end
      end
      a_cyc(0, 0, 0, 32'h0, 8'h00);
      n_cmp++;
      if (a_rvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL le_word_rv_drop: got %b, want 0", a_rvalid);
      end
   endtask

   task automatic test_priority_idle;
      a_cyc(1, 1, 0, 32'h5, 8'h3C);
      a_cyc(1, 1, 1, 32'h5, 8'h99);
      n_cmp++;
      if ({a_rvalid, a_din} !== 9'h0DE) begin
         n_fail++;
         $display("FAIL we_oe_write_only: got rv/din=%b/%h, want 0/de", a_rvalid, a_din);
      end
      a_cyc(1, 0, 1, 32'h5, 8'h00);
      n_cmp++;
      if ({a_rvalid, a_din} !== 9'h199) begin
         n_fail++;
         $display("FAIL we_oe_stored: got rv/din=%b/%h, want 1/99", a_rvalid, a_din);
      end
      a_cyc(0, 1, 0, 32'h5, 8'h11);
      n_cmp++;
      if (a_rvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL ce_low_we: rv got %b, want 0", a_rvalid);
      end
      a_cyc(0, 0, 1, 32'h5, 8'h00);
      n_cmp++;
      if ({a_rvalid, a_din} !== 9'h099) begin
         n_fail++;
         $display("FAIL ce_low_oe: got rv/din=%b/%h, want 0/99", a_rvalid, a_din);
      end
      a_cyc(1, 0, 1, 32'h5, 8'h00);
      n_cmp++;
      if ({a_rvalid, a_din} !== 9'h199) begin
         n_fail++;
         $display("FAIL ce_low_unchanged: got rv/din=%b/%h, want 1/99", a_rvalid, a_din);
      end
   endtask

   task automatic test_out_of_range;
      b_cyc(1, 1, 0, 32'h100, 8'h71);
      n_cmp++;
      if (b_err !== 1'b0) begin
         n_fail++;
         $display("FAIL oor_base_in_range: err got %b, want 0", b_err);
      end
      b_cyc(1, 1, 0, 32'h10F, 8'h7F);
      b_cyc(1, 1, 0, 32'hFF, 8'h11);
      n_cmp++;
      if (b_err !== 1'b1) begin
         n_fail++;
         $display("FAIL oor_wr_below: err got %b, want 1", b_err);
      end
      b_cyc(1, 1, 0, 32'h110, 8'h22);
      n_cmp++;
      if (b_err !== 1'b1) begin
         n_fail++;
         $display("FAIL oor_wr_above: err got %b, want 1", b_err);
      end
      b_cyc(0, 0, 0, 32'h0, 8'h00);
      n_cmp++;
      if (b_err !== 1'b0) begin
         n_fail++;
         $display("FAIL oor_err_pulse: err got %b, want 0", b_err);
      end
      b_cyc(1, 0, 1, 32'h100, 8'h00);
      n_cmp++;
      if ({b_rvalid, b_err, b_din} !== 10'h271) begin
         n_fail++;
         $display("FAIL oor_byte0_kept: got rv/err/din=%b/%b/%h, want 1/0/71", b_rvalid, b_err, b_din);
      end
      b_cyc(1, 0, 1, 32'h10F, 8'h00);
      n_cmp++;
      if ({b_rvalid, b_err, b_din} !== 10'h27F) begin
         n_fail++;
         $display("FAIL oor_byte15_kept: got rv/err/din=%b/%b/%h, want 1/0/7f", b_rvalid, b_err, b_din);
      end
      b_cyc(1, 0, 1, 32'h110, 8'h00);
      n_cmp++;
      if ({b_rvalid, b_err, b_din} !== 10'h300) begin
         n_fail++;
         $display("FAIL oor_read: got rv/err/din=%b/%b/%h, want 1/1/00", b_rvalid, b_err, b_din);
      end
      b_cyc(0, 0, 0, 32'h0, 8'h00);
      n_cmp++;
      if ({b_rvalid, b_err} !== 2'b00) begin
         n_fail++;
         $display("FAIL oor_read_pulse: got rv/err=%b/%b, want 0/0", b_rvalid, b_err);
      end
   endtask

   task automatic test_reset_mid_clear;
      int cnt;
      a_cyc(1, 1, 0, 32'hC, 8'h5A);
      a_cyc(1, 0, 1, 32'hC, 8'h00);
      n_cmp++;
      if ({a_rvalid, a_din} !== 9'h15A) begin
         n_fail++;
         $display("FAIL pre_reset_read: got rv/din=%b/%h, want 1/5a", a_rvalid, a_din);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({a_ready, a_rvalid, a_err, a_din} !== 11'd0) begin
         n_fail++;
         $display("FAIL async_reset_access: got rdy/rv/err/din=%b%b%b/%h, want 000/00", a_ready, a_rvalid, a_err, a_din);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (7) @(posedge clk);
      #1;
      n_cmp++;
      if (a_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_clear_ready: got %b, want 0", a_ready);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({a_ready, a_rvalid, a_err, a_din} !== 11'd0) begin
         n_fail++;
         $display("FAIL async_reset_clear: got rdy/rv/err/din=%b%b%b/%h, want 000/00", a_ready, a_rvalid, a_err, a_din);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      cnt = 0;
      while (a_ready !== 1'b1 && cnt < 40) begin
         @(posedge clk); #1;
         cnt++;
      end
      n_cmp++;
      if (cnt !== 16) begin
         n_fail++;
         $display("FAIL reclear_cycles: READY low for %0d cycles, want 16", cnt);
      end
      a_cyc(1, 0, 1, 32'hC, 8'h00);
      n_cmp++;
      if ({a_rvalid, a_din} !== 9'h100) begin
         n_fail++;
         $display("FAIL reclear_byte12: got rv/din=%b/%h, want 1/00", a_rvalid, a_din);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_le_word();
      test_priority_idle();
      test_out_of_range();
      test_reset_mid_clear();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/holo_data_mem.md
HOLO_DATA_MEM -- requirements
Module: holo_data_mem

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 10, log2 of the byte-array depth (DEPTH = 2**ADDR_BITS).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, the first byte address decoded by this block.
REQ-003 SHALL have parameter INIT_VAL, default 8'h00, the value written to every byte during the clear sequence.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port DATA_CE, input, 1, chip enable; no access occurs when low.
REQ-007 SHALL have port DATA_OE, input, 1, read request when high with DATA_WE low.
REQ-008 SHALL have port DATA_WE, input, 1, write request; takes priority over DATA_OE.
REQ-009 SHALL have port DATA_ADDR, input, 32, byte address from the core.
REQ-010 SHALL have port DATA_OUT, input, 8, write byte from the core.
REQ-011 SHALL have port DATA_IN, output, 8, read byte returned to the core.
REQ-012 SHALL have port RVALID, output, 1, one-cycle pulse marking DATA_IN as updated by a read.
REQ-013 SHALL have port READY, output, 1, high only when the block accepts accesses.
REQ-014 SHALL have port ERR, output, 1, one-cycle pulse on an out-of-range access.

Function
REQ-015 SHALL implement the FSM states CLEAR and SERVE; reset enters CLEAR.
REQ-016 SHALL, in CLEAR, write INIT_VAL to byte index CLR_CNT each cycle, with CLR_CNT running from 0 to DEPTH-1.
REQ-017 SHALL move to SERVE on the cycle after index DEPTH-1 is written; clear takes exactly DEPTH cycles.
REQ-018 SHALL hold READY low in CLEAR, ignore all bus inputs in CLEAR, and hold READY high in SERVE.
REQ-019 SHALL treat an access as accepted when READY, DATA_CE and (DATA_WE or DATA_OE) are all high on a rising edge.
REQ-020 SHALL compute OFF = DATA_ADDR - BASE_ADDR in 32-bit modulo arithmetic; the access is in range iff OFF < DEPTH.
REQ-021 SHALL, on an accepted in-range write, store DATA_OUT at OFF; DATA_IN and RVALID SHALL be unchanged/low.
REQ-022 SHALL, on an accepted in-range read, present mem[OFF] on DATA_IN and pulse RVALID on the following cycle (latency 1).
REQ-023 SHALL hold DATA_IN stable between reads.
REQ-024 SHALL support back-to-back reads, one result per cycle, with RVALID staying high across consecutive reads.
REQ-025 SHALL make a write visible to a read accepted in the immediately following cycle (no stale data).
REQ-026 SHALL, on an accepted out-of-range access, perform no write, drive DATA_IN to 8'h00 on a read, and pulse ERR for one cycle; RVALID SHALL also pulse for an out-of-range read.
REQ-027 SHALL treat DATA_WE high with DATA_OE high as a write only.
REQ-028 SHALL do nothing when DATA_CE is low, whatever DATA_WE and DATA_OE are.
REQ-029 SHALL compute address addition without wrap into range: BASE_ADDR + DEPTH overflowing 2**32 is a configuration error and is not supported.

Reset
REQ-030 SHALL, on rst_n low, immediately set DATA_IN=8'h00, RVALID=0, ERR=0, READY=0, CLR_CNT=0 and state=CLEAR.
REQ-031 SHALL, on reset asserted mid-clear or mid-access, drop the in-flight operation, then restart the clear from index 0.
REQ-032 SHALL be initialised by the clear sequence only; array contents are not reset asynchronously.

Structure
REQ-033 SHALL take the bus widths (ADDR_W=32, DATA_W=8) and the FSM state encoding from shared package holo_bus_pkg, which the core also uses.
REQ-034 SHALL place the storage array in sub-module holo_byte_ram (one synchronous write port, one synchronous read port, DEPTH x 8); the FSM, decode and error logic stay in holo_data_mem.

Verification
REQ-035 SHALL cover reset clear: release rst_n, ADDR_BITS=4 -> READY low for exactly 16 cycles, then high; a read of every byte returns 8'h00.
REQ-036 SHALL cover write then read: write 8'hA5 to 0x3, then read 0x3 on the next cycle -> DATA_IN=8'hA5 with RVALID high one cycle later.
REQ-037 SHALL cover a little-endian word: write 0xDEADBEEF as bytes 0x8..0xB, then read them back-to-back -> EF, BE, AD, DE on consecutive cycles, RVALID high for 4 cycles.
REQ-038 SHALL cover out of range: BASE_ADDR=0x100, write to 0xFF and 0x110 -> ERR pulses twice, no array change; read 0x110 -> DATA_IN=00, ERR=1.
REQ-039 SHALL cover priority and idle: DATA_WE=DATA_OE=1 -> write only, RVALID=0; DATA_CE=0 with DATA_WE=1 -> memory unchanged.
REQ-040 SHALL cover reset mid-clear: assert rst_n low at clear index 7 -> outputs zero immediately; after release, a full DEPTH-cycle clear runs again.
